// File: rtl/lsu_mem_bridge.sv
// Load/store bridge from the RV32I data path to a word-only RAM port.
// Sub-word loads are extracted and extended; SB/SH are done as read-modify-write.
module lsu_mem_bridge #(
    parameter int MEM_SIZE = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        core_done,
    output logic        core_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE - 3);

    logic [1:0]       state, state_nxt;
    logic             we_q, err_q;
    logic [31:0]      cap_word, rdata_hold;
    logic             f3_ok, misalign, out_of_range, req_err, is_sw;
    logic [3:0][7:0]  rd_lanes, wr_lanes, merged, cap_lanes;
    logic [3:0]       lane_sel;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      load_val, done_rdata;

    assign mem_addr = {core_addr[31:2], 2'b00};

    always_comb begin
        if (core_we)
            f3_ok = (core_funct3 == 3'b000) || (core_funct3 == 3'b001) || (core_funct3 == 3'b010);
        else
            f3_ok = !((core_funct3 == 3'b011) || (core_funct3 == 3'b110) || (core_funct3 == 3'b111));
        misalign     = ((core_funct3[1:0] == 2'b01) && core_addr[0]) ||
                       ((core_funct3[1:0] == 2'b10) && (core_addr[1:0] != 2'b00));
        out_of_range = mem_addr >= MEM_LIMIT;
        req_err      = !f3_ok || misalign || out_of_range;
        is_sw        = core_we && (core_funct3 == 3'b010);
    end

    // Store data replicated across lanes; lane_sel picks which RAM bytes it replaces.
    assign rd_lanes = mem_rdata;
    assign wr_lanes = core_funct3[0] ? {2{core_wdata[15:0]}} : {4{core_wdata[7:0]}};

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_lane
            localparam logic [1:0] LANE = 2'(i);
            assign lane_sel[i] = core_funct3[0] ? (core_addr[1] == LANE[1])
                                                : (core_addr[1:0] == LANE);
            assign merged[i]   = lane_sel[i] ? wr_lanes[i] : rd_lanes[i];
        end
    endgenerate

    assign cap_lanes = cap_word;
    assign ld_byte   = cap_lanes[core_addr[1:0]];
    assign ld_half   = core_addr[1] ? cap_word[31:16] : cap_word[15:0];

    always_comb begin
        case (core_funct3)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = cap_word;
        endcase
        done_rdata = (!we_q && !err_q) ? load_val : 32'd0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (core_req) state_nxt = req_err ? S_DONE : (is_sw ? S_WRITE : S_READ);
            S_READ:  state_nxt = we_q ? S_WRITE : S_DONE;
            S_WRITE: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            cap_word   <= 32'd0;
            rdata_hold <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (core_req) begin
                    we_q  <= core_we;
                    err_q <= req_err;
                    if (is_sw && !req_err) mem_wdata <= core_wdata;
                end
                S_READ: begin
                    cap_word <= mem_rdata;
                    if (we_q) mem_wdata <= merged;
                end
                S_DONE:  rdata_hold <= done_rdata;
                default: ;
            endcase
        end
    end

    // Strobes decode from state alone, so an async reset drops mem_write at once.
    assign mem_read   = (state == S_READ);
    assign mem_write  = (state == S_WRITE);
    assign core_done  = (state == S_DONE);
    assign core_err   = core_done && err_q;
    assign core_stall = core_req && (state != S_DONE);
    assign core_rdata = core_done ? done_rdata : rdata_hold;
endmodule
